cbm_issue_queue: RTL

- Request buffer directly upstream of the column-bypass multiplier (CBM).
- Accepts MUL requests (operands plus destination register index) from the issue stage over a valid/ready handshake and holds them in a small FIFO.
- Dispatches requests to the CBM one at a time using its start/busy/done protocol, with at most one multiply in flight.

---
 rtl/cbm_pkg.sv | 26 ++
 rtl/cbm_popcount.sv | 20 ++
 rtl/cbm_issue_queue.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/cbm_pkg.sv
// rtl/cbm_pkg.sv - shared widths, FSM encoding and request type for the CBM issue queue
//
// Contents:
//   XLEN, RD_W   operand and destination-index widths
//   PC_W         popcount result width (0..32 needs 6 bits)
//   cbm_state_e  dispatch FSM states IDLE / ISSUE / WAIT
//   cbm_req_t    queued request {a, b, rd}
package cbm_pkg;

  localparam int XLEN = 32;
  localparam int RD_W = 5;
  localparam int PC_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } cbm_state_e;

  typedef struct packed {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [RD_W-1:0] rd;
  } cbm_req_t;

endpackage

// File: rtl/cbm_popcount.sv
// rtl/cbm_popcount.sv - combinational population count of a 32-bit word
//
// Ports:
//   val_i  in   32  word to count
//   cnt_o  out  6   number of set bits in val_i
module cbm_popcount
  import cbm_pkg::*;
(
  input  logic [XLEN-1:0] val_i,
  output logic [PC_W-1:0] cnt_o
);

  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < XLEN; i++) begin
      cnt_o = cnt_o + PC_W'(val_i[i]);
    end
  end

endmodule

// File: rtl/cbm_issue_queue.sv
// rtl/cbm_issue_queue.sv - request FIFO and single-outstanding dispatcher in front of the CBM
//
// Optional build macro: CBM_OPERAND_SWAP_EN (put the operand with fewer set bits on A).
//
// Ports:
//   clk_i, rst_i                  clock, synchronous active-high reset
//   req_valid_i / req_ready_o     issue-stage handshake; ready = !full
//   req_a_i, req_b_i, req_rd_i    request operands and destination index
//   flush_i                       drop every queued, not yet dispatched entry
//   cbm_start_o                   one-cycle start pulse to the CBM
//   cbm_op_a_o, cbm_op_b_o        registered operands, held until the next dispatch
//   cbm_rd_idx_o                  registered destination index
//   cbm_busy_i, cbm_done_i        CBM status / result-valid pulse
//   inflight_o                    a dispatched multiply has not completed
//   count_o                       number of queued entries (0..DEPTH)
module cbm_issue_queue
  import cbm_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [XLEN-1:0] req_a_i,
  input  logic [XLEN-1:0] req_b_i,
  input  logic [RD_W-1:0] req_rd_i,
  input  logic            flush_i,
  output logic            cbm_start_o,
  output logic [XLEN-1:0] cbm_op_a_o,
  output logic [XLEN-1:0] cbm_op_b_o,
  output logic [RD_W-1:0] cbm_rd_idx_o,
  input  logic            cbm_busy_i,
  input  logic            cbm_done_i,
  output logic            inflight_o,
  output logic [AW:0]     count_o
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  cbm_req_t        mem_q [DEPTH];
  cbm_req_t        mem_d [DEPTH];
  logic [AW-1:0]   wptr_q, wptr_d;
  logic [AW-1:0]   rptr_q, rptr_d;
  logic [AW:0]     count_q, count_d;
  cbm_state_e      state_q, state_d;
  logic            start_q, start_d;
  logic            inflight_q, inflight_d;
  logic [XLEN-1:0] op_a_q, op_a_d;
  logic [XLEN-1:0] op_b_q, op_b_d;
  logic [RD_W-1:0] rd_q, rd_d;

  cbm_req_t        head;
  logic [XLEN-1:0] head_a;
  logic [XLEN-1:0] head_b;
  logic            full;
  logic            push;
  logic            pop;

  assign head = mem_q[rptr_q];

`ifdef CBM_OPERAND_SWAP_EN
  logic [PC_W-1:0] pc_a;
  logic [PC_W-1:0] pc_b;
  logic            swap;

  cbm_popcount u_pc_a (.val_i(head.a), .cnt_o(pc_a));
  cbm_popcount u_pc_b (.val_i(head.b), .cnt_o(pc_b));

  // CBM latency follows popcount(A); the low product word is commutative,
  // so the sparser operand goes on A. Ties keep the original order.
  assign swap   = (pc_b < pc_a);
  assign head_a = swap ? head.b : head.a;
  assign head_b = swap ? head.a : head.b;
`else
  assign head_a = head.a;
  assign head_b = head.b;
`endif

  always_comb begin
    full = (count_q == FULL_CNT);
    // Flush wins over a same-cycle push; there is no pop-to-free bypass when full.
    push = req_valid_i && !full && !flush_i;
    pop  = (state_q == ST_IDLE) && (count_q != '0) && !cbm_busy_i;

    mem_d = mem_q;
    if (push) begin
      mem_d[wptr_q] = '{a: req_a_i, b: req_b_i, rd: req_rd_i};
    end

    state_d = state_q;
    start_d = 1'b0;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    rd_d    = rd_q;
    case (state_q)
      ST_IDLE: begin
        if (pop) begin
          state_d = ST_ISSUE;
          start_d = 1'b1;
          op_a_d  = head_a;
          op_b_d  = head_b;
          rd_d    = head.rd;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (cbm_done_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    inflight_d = (state_d != ST_IDLE);

    // A pop coinciding with flush still dispatches: the head was read above.
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      wptr_d  = wptr_q + AW'(push);
      rptr_d  = rptr_q + AW'(pop);
      count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
    if (rst_i) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      state_q    <= ST_IDLE;
      start_q    <= 1'b0;
      inflight_q <= 1'b0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      rd_q       <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      state_q    <= state_d;
      start_q    <= start_d;
      inflight_q <= inflight_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      rd_q       <= rd_d;
    end
  end

  assign req_ready_o  = !full;
  assign cbm_start_o  = start_q;
  assign cbm_op_a_o   = op_a_q;
  assign cbm_op_b_o   = op_b_q;
  assign cbm_rd_idx_o = rd_q;
  assign inflight_o   = inflight_q;
  assign count_o      = count_q;

endmodule
